mem_arbiter: RTL and testbench

Shares one unified memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage load/store) of the pipelined CPU. It has a single outstanding bus transaction and a variable-latency ready handshake, which gives the unused MIO_ready path a real function. It returns per-requester read data and one-cycle valid pulses, and it generates stall signals that the pipeline ORs into its pause logic. It sits between SCPU's PC_out/inst_in and Addr_out/Data_out/Data_in ports and the external memory/MIO bus.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arb_timeout.sv | 31 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/grant encodings and the arbitration rule
// used by the unified memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    IBUSY = 2'b01,
    DBUSY = 2'b10
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // Fetches carry no width/sign code on the bus
  localparam logic [2:0] FETCH_CTRL = 3'b000;

  // Data wins when it is the only eligible requester, or on a tie when
  // fetch was the last one served
  function automatic logic grant_to_data(input logic fetch_elig,
                                         input logic data_elig,
                                         input grant_t last);
    return data_elig && (!fetch_elig || (last == GRANT_FETCH));
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: watchdog that counts busy cycles without bus_ready and
// flags the cycle in which the limit is reached. Only exists when
// MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Count stalled busy cycles; cleared whenever no transaction is active
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign expired = inc && (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// access with a single outstanding transaction and a ready handshake.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_ctrl,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [2:0]        bus_ctrl,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              bus_err
);

  arb_state_t state;
  grant_t     last_grant;
  logic       fetch_elig;
  logic       data_elig;
  logic       take_data;
  logic       busy;
  logic       timeout_hit;

  // A requester whose completion pulse is showing this cycle is not re-accepted
  assign fetch_elig = if_req & ~if_valid;
  assign data_elig  = d_req & ~d_valid;
  assign take_data  = grant_to_data(fetch_elig, data_elig, last_grant);
  assign busy       = (state != IDLE);

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (~busy),
    .inc    (busy & ~bus_ready),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Arbitration, transaction tracking and registered completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_FETCH;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_ctrl   <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_elig || data_elig) begin
            bus_req <= 1'b1;
            if (take_data) begin
              bus_we     <= d_we;
              bus_addr   <= d_addr;
              bus_wdata  <= d_wdata;
              bus_ctrl   <= d_ctrl;
              last_grant <= GRANT_DATA;
              state      <= DBUSY;
            end else begin
              bus_we     <= 1'b0;
              bus_addr   <= if_addr;
              bus_wdata  <= '0;
              bus_ctrl   <= FETCH_CTRL;
              last_grant <= GRANT_FETCH;
              state      <= IBUSY;
            end
          end
        end
        IBUSY: begin
          if (bus_ready) begin
            if_rdata <= bus_rdata;
            if_valid <= 1'b1;
            bus_req  <= 1'b0;
            state    <= IDLE;
          end else if (timeout_hit) begin
            if_rdata <= '0;
            if_valid <= 1'b1;
            bus_err  <= 1'b1;
            bus_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        DBUSY: begin
          if (bus_ready) begin
            if (!bus_we) d_rdata <= bus_rdata;
            d_valid <= 1'b1;
            bus_req <= 1'b0;
            state   <= IDLE;
          end else if (timeout_hit) begin
            if (!bus_we) d_rdata <= '0;
            d_valid <= 1'b1;
            bus_err <= 1'b1;
            bus_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written multi-cycle corner
// cases and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_ctrl;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_ctrl;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .if_stall (if_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ctrl   (d_ctrl),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .d_stall  (d_stall),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ctrl (bus_ctrl),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .bus_err  (bus_err)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ifr;
    logic        dr;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_br;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        e_dv;
    logic        e_is;
    logic        e_ds;
    logic [31:0] e_ir;
    logic [31:0] e_dr;
  } vec_t;

  function automatic vec_t mk(logic rst, logic ifr, logic dr, logic rdy, logic [31:0] rdata,
                              logic e_br, logic [31:0] e_addr, logic e_iv, logic e_dv,
                              logic e_is, logic e_ds, logic [31:0] e_ir, logic [31:0] e_dr);
    vec_t v;
    v.rst = rst; v.ifr = ifr; v.dr = dr; v.rdy = rdy; v.rdata = rdata;
    v.e_br = e_br; v.e_addr = e_addr; v.e_iv = e_iv; v.e_dv = e_dv;
    v.e_is = e_is; v.e_ds = e_ds; v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    if_req    = v.ifr;
    d_req     = v.dr;
    bus_ready = v.rdy;
    bus_rdata = v.rdata;
    tick();
  endtask

  // Reference model: one outstanding transaction, alternating tie-break
  logic        m_busy, m_own_d, m_last_d, m_we, m_iv, m_dv, m_err;
  logic [31:0] m_addr, m_wdata, m_ir, m_dr;
  logic [2:0]  m_ctrl;
  int          m_wait;

  task automatic modelReset;
    m_busy = 0; m_own_d = 0; m_last_d = 0; m_we = 0; m_iv = 0; m_dv = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_ir = 0; m_dr = 0; m_ctrl = 0; m_wait = 0;
  endtask

  task automatic modelStep;
    logic ei, ed, take_d, n_iv, n_dv, n_err;
    ei = if_req && !m_iv;
    ed = d_req && !m_dv;
    n_iv = 0; n_dv = 0; n_err = 0;
    if (!m_busy) begin
      if (ei || ed) begin
        take_d = ed && (!ei || !m_last_d);
        m_busy = 1; m_own_d = take_d; m_last_d = take_d; m_wait = 0;
        if (take_d) begin
          m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_ctrl = d_ctrl;
        end else begin
          m_we = 0; m_addr = if_addr; m_ctrl = 3'b000;
        end
      end
    end else if (bus_ready) begin
      m_busy = 0;
      if (m_own_d) begin
        n_dv = 1;
        if (!m_we) m_dr = bus_rdata;
      end else begin
        n_iv = 1;
        m_ir = bus_rdata;
      end
    end else begin
      m_wait++;
`ifdef MEM_ARB_TIMEOUT_EN
      if (m_wait == TO) begin
        m_busy = 0; n_err = 1;
        if (m_own_d) begin
          n_dv = 1;
          if (!m_we) m_dr = 0;
        end else begin
          n_iv = 1;
          m_ir = 0;
        end
      end
`endif
    end
    m_iv = n_iv; m_dv = n_dv; m_err = n_err;
  endtask

  vec_t vecs[18];

  initial begin
    reset = 1; if_req = 0; d_req = 0; d_we = 0; bus_ready = 0; bus_rdata = 0;
    if_addr = 32'h10; d_addr = 32'h100; d_wdata = 0; d_ctrl = 3'b100;

    // Fetch-only, held request, then tie alternation
    vecs[0]  = mk(1,0,0,0,0,         0,0,      0,0,0,0,0,0);
    vecs[1]  = mk(0,1,0,0,0,         1,'h10,   0,0,1,0,0,0);
    vecs[2]  = mk(0,1,0,1,'h93,      0,'h10,   1,0,0,0,'h93,0);
    vecs[3]  = mk(0,1,0,1,'h55,      0,'h10,   0,0,1,0,'h93,0);
    vecs[4]  = mk(0,1,0,0,0,         1,'h10,   0,0,1,0,'h93,0);
    vecs[5]  = mk(0,1,0,1,'h13,      0,'h10,   1,0,0,0,'h13,0);
    vecs[6]  = mk(0,0,0,0,0,         0,'h10,   0,0,0,0,'h13,0);
    vecs[7]  = mk(1,0,0,0,0,         0,0,      0,0,0,0,0,0);
    vecs[8]  = mk(0,1,1,0,0,         1,'h100,  0,0,1,1,0,0);
    vecs[9]  = mk(0,1,1,1,'hD1,      0,'h100,  0,1,1,0,0,'hD1);
    vecs[10] = mk(0,1,0,0,0,         1,'h10,   0,0,1,0,0,'hD1);
    vecs[11] = mk(0,1,0,1,'hF1,      0,'h10,   1,0,0,0,'hF1,'hD1);
    vecs[12] = mk(0,0,0,0,0,         0,'h10,   0,0,0,0,'hF1,'hD1);
    vecs[13] = mk(0,1,1,0,0,         1,'h100,  0,0,1,1,'hF1,'hD1);
    vecs[14] = mk(0,1,1,1,'hD2,      0,'h100,  0,1,1,0,'hF1,'hD2);
    vecs[15] = mk(0,1,0,0,0,         1,'h10,   0,0,1,0,'hF1,'hD2);
    vecs[16] = mk(0,1,0,1,'h77,      0,'h10,   1,0,0,0,'h77,'hD2);
    vecs[17] = mk(0,0,0,0,0,         0,'h10,   0,0,0,0,'h77,'hD2);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d bus_req", i),  32'(bus_req),  32'(vecs[i].e_br));
      checkOutput($sformatf("vec%0d bus_addr", i), bus_addr,      vecs[i].e_addr);
      checkOutput($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_iv));
      checkOutput($sformatf("vec%0d d_valid", i),  32'(d_valid),  32'(vecs[i].e_dv));
      checkOutput($sformatf("vec%0d if_stall", i), 32'(if_stall), 32'(vecs[i].e_is));
      checkOutput($sformatf("vec%0d d_stall", i),  32'(d_stall),  32'(vecs[i].e_ds));
      checkOutput($sformatf("vec%0d if_rdata", i), if_rdata,      vecs[i].e_ir);
      checkOutput($sformatf("vec%0d d_rdata", i),  d_rdata,       vecs[i].e_dr);
    end

    // Store with slow ready; inputs scrambled while busy must not leak onto the bus
    reset = 0; bus_ready = 0;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D; d_ctrl = 3'b010;
    for (int c = 0; c < 5; c++) begin
      tick();
      d_addr = 32'h0BAD_0000; d_wdata = 32'h1234_5678; d_ctrl = 3'b111; d_we = 0;
      checkOutput($sformatf("st%0d bus_req", c),   32'(bus_req),  32'd1);
      checkOutput($sformatf("st%0d bus_we", c),    32'(bus_we),   32'd1);
      checkOutput($sformatf("st%0d bus_addr", c),  bus_addr,      32'h200);
      checkOutput($sformatf("st%0d bus_wdata", c), bus_wdata,     32'hCAFE_F00D);
      checkOutput($sformatf("st%0d bus_ctrl", c),  32'(bus_ctrl), 32'd2);
      checkOutput($sformatf("st%0d d_stall", c),   32'(d_stall),  32'd1);
      checkOutput($sformatf("st%0d d_valid", c),   32'(d_valid),  32'd0);
    end
    bus_ready = 1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    checkOutput("st d_valid",  32'(d_valid), 32'd1);
    checkOutput("st d_rdata",  d_rdata,      32'hD2);
    checkOutput("st bus_req",  32'(bus_req), 32'd0);
    checkOutput("st bus_err",  32'(bus_err), 32'd0);
    d_req = 0; bus_ready = 0;
    tick();
    checkOutput("st d_valid once", 32'(d_valid), 32'd0);

    // Fetch with bus_ready never asserted
    if_req = 1; if_addr = 32'h40;
    tick();
    for (int c = 0; c < TO; c++) begin
      checkOutput($sformatf("to busy%0d bus_req", c), 32'(bus_req),  32'd1);
      checkOutput($sformatf("to busy%0d if_valid", c), 32'(if_valid), 32'd0);
      tick();
    end
`ifdef MEM_ARB_TIMEOUT_EN
    checkOutput("to if_valid", 32'(if_valid), 32'd1);
    checkOutput("to bus_err",  32'(bus_err),  32'd1);
    checkOutput("to if_rdata", if_rdata,      32'd0);
    checkOutput("to bus_req",  32'(bus_req),  32'd0);
    if_req = 0;
    tick();
    checkOutput("to bus_err once", 32'(bus_err), 32'd0);
`else
    for (int c = 0; c < 16; c++) begin
      checkOutput($sformatf("hold%0d bus_req", c), 32'(bus_req), 32'd1);
      checkOutput($sformatf("hold%0d bus_err", c), 32'(bus_err), 32'd0);
      tick();
    end
    if_req = 0;
`endif

    // Reset while a load is outstanding
    reset = 1;
    tick();
    reset = 0; d_req = 1; d_we = 0; d_addr = 32'h300; d_ctrl = 3'b101;
    tick();
    checkOutput("rst busy bus_req",  32'(bus_req), 32'd1);
    checkOutput("rst busy bus_addr", bus_addr,     32'h300);
    tick();
    reset = 1; bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    checkOutput("rst bus_req",   32'(bus_req),   32'd0);
    checkOutput("rst d_valid",   32'(d_valid),   32'd0);
    checkOutput("rst d_rdata",   d_rdata,        32'd0);
    checkOutput("rst if_rdata",  if_rdata,       32'd0);
    checkOutput("rst bus_addr",  bus_addr,       32'd0);
    checkOutput("rst bus_ctrl",  32'(bus_ctrl),  32'd0);
    checkOutput("rst bus_err",   32'(bus_err),   32'd0);
    reset = 0; d_req = 0;
    tick();
    checkOutput("rst after d_valid", 32'(d_valid), 32'd0);
    checkOutput("rst after bus_req", 32'(bus_req), 32'd0);

    // Randomized traffic against the reference model
    reset = 1; if_req = 0; d_req = 0; bus_ready = 0;
    tick();
    modelReset();
    reset = 0;
    for (int n = 0; n < 400; n++) begin
      if (!if_req) if_req = ($urandom_range(0, 9) < 4);
      else if (m_iv) if_req = 1'($urandom_range(0, 1));
      if (!d_req) d_req = ($urandom_range(0, 9) < 4);
      else if (m_dv) d_req = 1'($urandom_range(0, 1));
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      d_we = 1'($urandom_range(0, 1)); d_ctrl = 3'($urandom_range(0, 7));
      bus_ready = ($urandom_range(0, 9) < 3); bus_rdata = $urandom;
      modelStep();
      tick();
      checkOutput($sformatf("rnd%0d bus_req", n),  32'(bus_req),  32'(m_busy));
      checkOutput($sformatf("rnd%0d bus_addr", n), bus_addr,      m_addr);
      checkOutput($sformatf("rnd%0d bus_we", n),   32'(bus_we),   32'(m_we));
      checkOutput($sformatf("rnd%0d bus_ctrl", n), 32'(bus_ctrl), 32'(m_ctrl));
      if (m_own_d) checkOutput($sformatf("rnd%0d bus_wdata", n), bus_wdata, m_wdata);
      checkOutput($sformatf("rnd%0d if_valid", n), 32'(if_valid), 32'(m_iv));
      checkOutput($sformatf("rnd%0d d_valid", n),  32'(d_valid),  32'(m_dv));
      checkOutput($sformatf("rnd%0d if_rdata", n), if_rdata,      m_ir);
      checkOutput($sformatf("rnd%0d d_rdata", n),  d_rdata,       m_dr);
      checkOutput($sformatf("rnd%0d bus_err", n),  32'(bus_err),  32'(m_err));
      checkOutput($sformatf("rnd%0d if_stall", n), 32'(if_stall), 32'(if_req & ~m_iv));
      checkOutput($sformatf("rnd%0d d_stall", n),  32'(d_stall),  32'(d_req & ~m_dv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
